neural_network: RTL and testbench



---
 rtl/nn_pkg.sv | 30 +++
 rtl/nn_neuron.sv | 38 +++
 rtl/neural_network.sv | 108 ++++++++++
 tb/tb_neural_network.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nn_pkg
// Description : Shared sizes, FSM state type and neuron-record byte offsets
//               for the single-layer perceptron.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int DATA_W    = 8;
    localparam int N         = 4;
    localparam int ACC_W     = 2*DATA_W + 2;
    localparam int K_W       = (N > 1) ? $clog2(N) : 1;

    // Each neuron record is 6 bytes: w0..w3 at the bottom, then bias, then threshold.
    localparam int REC_BYTES = N + 2;
    localparam int W_OFS     = 0;
    localparam int B_OFS     = N;
    localparam int TH_OFS    = N + 1;
    localparam int REC_BITS  = REC_BYTES*DATA_W;
    localparam int P_BYTES   = N*REC_BYTES;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2
    } state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_neuron.sv
`default_nettype none
// ============================================================================
// Module      : nn_neuron
// Description : Combinational N-way multiply-accumulate with threshold
//               compare. Build option NN_THRESH_GE_EN selects acc >= th
//               instead of the default acc > th.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_neuron
    import nn_pkg::*;
(
    input  logic [N*DATA_W-1:0] x_i,
    input  logic [N*DATA_W-1:0] w_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [DATA_W-1:0]   th_i,
    output logic [ACC_W-1:0]    acc_o,
    output logic                fire_o
);

    logic [2*DATA_W-1:0] prod;

    always_comb begin
        prod  = '0;
        acc_o = ACC_W'(b_i);
        for (int i = 0; i < N; i++) begin
            prod  = x_i[i*DATA_W +: DATA_W] * w_i[i*DATA_W +: DATA_W];
            acc_o = acc_o + ACC_W'(prod);
        end
    end

`ifdef NN_THRESH_GE_EN
    assign fire_o = (acc_o >= ACC_W'(th_i));
`else
    assign fire_o = (acc_o > ACC_W'(th_i));
`endif

endmodule : nn_neuron
`default_nettype wire

// File: rtl/neural_network.sv
`default_nettype none
// ============================================================================
// Module      : neural_network
// Description : Byte-serial 4-input / 4-neuron threshold perceptron. One
//               shared nn_neuron is time-multiplexed over the neurons.
//               Build option NN_THRESH_GE_EN (in nn_neuron) selects >= firing.
// Revision    : 1.0 - initial release
// ============================================================================
module neural_network
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              changes,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] final_output
);

    state_t                   state_q;
    logic                     changes_q;
    logic [N*DATA_W-1:0]      x_q;
    logic [P_BYTES*DATA_W-1:0] p_q;
    logic [K_W-1:0]           k_q;
    logic [N-1:0]             fire_q;
    logic [DATA_W-1:0]        final_q;

    logic                     chg_rise;
    logic [N*DATA_W-1:0]      x_d;
    logic [P_BYTES*DATA_W-1:0] p_d;
    logic [REC_BITS-1:0]      rec;
    logic [N-1:0]             fire_d;
    logic [ACC_W-1:0]         acc_unused;
    logic                     fire;

    assign chg_rise = changes & ~changes_q;

    // Newest byte enters at the bottom, so the first byte sent ends up highest.
    assign x_d = {x_q[(N-1)*DATA_W-1:0], data_in};
    assign p_d = {p_q[(P_BYTES-1)*DATA_W-1:0], data_in};

    always_comb begin
        rec = '0;
        for (int r = 0; r < N; r++) begin
            if (k_q == K_W'(r)) begin
                rec = p_q[r*REC_BITS +: REC_BITS];
            end
        end
    end

    nn_neuron u_neuron (
        .x_i    (x_q),
        .w_i    (rec[W_OFS*DATA_W +: N*DATA_W]),
        .b_i    (rec[B_OFS*DATA_W +: DATA_W]),
        .th_i   (rec[TH_OFS*DATA_W +: DATA_W]),
        .acc_o  (acc_unused),
        .fire_o (fire)
    );

    always_comb begin
        fire_d      = fire_q;
        fire_d[k_q] = fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD_X;
            changes_q <= 1'b0;
            x_q       <= '0;
            p_q       <= '0;
            k_q       <= '0;
            fire_q    <= '0;
            final_q   <= '0;
        end else begin
            changes_q <= changes;
            case (state_q)
                LOAD_X: begin
                    if (chg_rise) begin
                        state_q <= LOAD_W;
                    end else begin
                        x_q <= x_d;
                    end
                end
                LOAD_W: begin
                    if (chg_rise) begin
                        state_q <= COMPUTE;
                        k_q     <= '0;
                        fire_q  <= '0;
                    end else begin
                        p_q <= p_d;
                    end
                end
                COMPUTE: begin
                    fire_q <= fire_d;
                    k_q    <= k_q + 1'b1;
                    if (k_q == K_W'(N-1)) begin
                        final_q <= DATA_W'(fire_d);
                        state_q <= LOAD_X;
                    end
                end
                default: state_q <= LOAD_X;
            endcase
        end
    end

    assign final_output = final_q;

endmodule : neural_network
`default_nettype wire

// File: tb/tb_neural_network.sv
`default_nettype none
// ============================================================================
// Module      : tb_neural_network
// Description : Directed self-checking bench for neural_network.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neural_network;
    import nn_pkg::*;

    logic       clk;
    logic       reset;
    logic       changes;
    logic [7:0] data_in;
    logic [7:0] final_output;

    int total;
    int bad;

    neural_network dut (
        .clk          (clk),
        .reset        (reset),
        .changes      (changes),
        .data_in      (data_in),
        .final_output (final_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        changes = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Single-cycle strobe; returns 1 ns after the sampling edge E.
    task automatic strobe();
        changes = 1'b1;
        @(posedge clk);
        #1;
        changes = 1'b0;
    endtask

    task automatic load_x(input logic [7:0] a3, a2, a1, a0);
        send_byte(a3); send_byte(a2); send_byte(a1); send_byte(a0);
    endtask

    task automatic send_neuron(input logic [7:0] th, b, w3, w2, w1, w0);
        send_byte(th); send_byte(b);
        send_byte(w3); send_byte(w2); send_byte(w1); send_byte(w0);
    endtask

    task automatic load_nominal_p(input logic [7:0] th0);
        send_neuron(8'd0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4);
        send_neuron(8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
        send_neuron(8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2);
        send_neuron(th0,  8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    endtask

    task automatic test_reset();
        reset = 1'b1; changes = 1'b0; data_in = 8'h00;
        #12;
        total++;
        if (final_output !== 8'h00) begin
            bad++; $display("FAIL reset_out: got %h want 00", final_output);
        end
        total++;
        if (dut.state_q !== LOAD_X) begin
            bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, LOAD_X);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        logic [17:0] exp_acc [4];
        exp_acc = '{18'd35, 18'd70, 18'd105, 18'd140};
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        strobe();
        load_nominal_p(8'd0);
        strobe();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dut.u_neuron.acc_o !== exp_acc[k]) begin
                bad++; $display("FAIL nominal_acc%0d: got %0d want %0d", k, dut.u_neuron.acc_o, exp_acc[k]);
            end
            if (k == 3) begin
                total++;
                if (final_output !== 8'h00) begin
                    bad++; $display("FAIL nominal_early: got %h want 00 at E+3", final_output);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (final_output !== 8'h0F) begin
            bad++; $display("FAIL nominal_out: got %h want 0F at E+4", final_output);
        end
        total++;
        if (dut.state_q !== LOAD_X) begin
            bad++; $display("FAIL nominal_state: got %0d want %0d", dut.state_q, LOAD_X);
        end
    endtask

    task automatic test_threshold();
        logic [7:0] exp;
`ifdef NN_THRESH_GE_EN
        exp = 8'h0F;
`else
        exp = 8'h0E;
`endif
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        strobe();
        load_nominal_p(8'd35);
        strobe();
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (final_output !== exp) begin
            bad++; $display("FAIL threshold_out: got %h want %h", final_output, exp);
        end
    endtask

    task automatic test_zero();
        logic [7:0] exp [2];
        exp = '{8'h00, 8'h02};
        for (int t = 0; t < 2; t++) begin
            load_x(8'd10, 8'd9, 8'd8, 8'd7);
            strobe();
            send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            send_neuron(8'd0, (t == 1) ? 8'd1 : 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            strobe();
            repeat (4) begin @(posedge clk); #1; end
            total++;
            if (final_output !== exp[t]) begin
                bad++; $display("FAIL zero_out%0d: got %h want %h", t, final_output, exp[t]);
            end
        end
    endtask

    task automatic test_extra_held();
        send_byte(8'd99); send_byte(8'd99);
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        data_in = 8'h00;
        changes = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        changes = 1'b0;
        total++;
        if (dut.x_q !== 32'h0A090807) begin
            bad++; $display("FAIL extra_x: got %h want 0a090807", dut.x_q);
        end
        total++;
        if (dut.state_q !== LOAD_W) begin
            bad++; $display("FAIL held_state: got %0d want %0d", dut.state_q, LOAD_W);
        end
        load_nominal_p(8'd0);
        strobe();
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (final_output !== 8'h0F) begin
            bad++; $display("FAIL held_out: got %h want 0F", final_output);
        end
    endtask

    task automatic test_reset_mid();
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        strobe();
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (final_output !== 8'h00) begin
            bad++; $display("FAIL midreset_out: got %h want 00", final_output);
        end
        total++;
        if (dut.state_q !== LOAD_X) begin
            bad++; $display("FAIL midreset_state: got %0d want %0d", dut.state_q, LOAD_X);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        strobe();
        load_nominal_p(8'd0);
        strobe();
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (final_output !== 8'h0F) begin
            bad++; $display("FAIL midreset_reload: got %h want 0F", final_output);
        end
    endtask

    task automatic test_strobe_compute();
        load_x(8'd10, 8'd9, 8'd8, 8'd7);
        strobe();
        send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        send_neuron(8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        send_neuron(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        strobe();                       // now 1 ns after E
        @(posedge clk); #1;             // after E+1
        changes = 1'b1;                 // rising edge seen at E+2
        @(posedge clk); #1;
        changes = 1'b0;
        @(posedge clk); #1;             // after E+3
        @(posedge clk); #1;             // after E+4
        total++;
        if (final_output !== 8'h02) begin
            bad++; $display("FAIL compstrobe_out: got %h want 02", final_output);
        end
        total++;
        if (dut.state_q !== LOAD_X) begin
            bad++; $display("FAIL compstrobe_state: got %0d want %0d", dut.state_q, LOAD_X);
        end
        send_byte(8'h00);
        total++;
        if (dut.state_q !== LOAD_X) begin
            bad++; $display("FAIL compstrobe_after: got %0d want %0d", dut.state_q, LOAD_X);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_nominal();
        test_threshold();
        test_zero();
        test_extra_held();
        test_reset_mid();
        test_strobe_compute();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_neural_network
`default_nettype wire
